decoder_2x4_stream: RTL and testbench

//   Registered stream decoder: accepts 2-bit binary codes {o1,o2} from the 4x2

---
 rtl/decoder_2x4_stream.sv | 65 ++++++
 tb/tb_decoder_2x4_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2x4_stream.sv
// rtl/decoder_2x4_stream.sv - registered binary-to-one-hot stream decoder with 2-entry buffer
module decoder_2x4_stream #(
  parameter int CODE_W = 2,
  parameter int CNT_W  = 8,
  parameter int OUT_W  = 2**CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_onehot,
  output logic [CNT_W-1:0]  dec_count
);

  logic [OUT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  // in_ready depends on state, en and reset only; out_ready never feeds it.
  assign in_ready   = rst_n & en & (occ != 2'd2);
  assign out_valid  = (occ != 2'd0);
  assign out_onehot = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= OUT_W'(1) << in_code;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= '0;
    end else if (pop && (dec_count != {CNT_W{1'b1}})) begin
      dec_count <= dec_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// tb/tb_decoder_2x4_stream.sv - directed self-checking bench for decoder_2x4_stream
module tb_decoder_2x4_stream;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [1:0] in_code;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_onehot;
  logic [7:0] dec_count;
  logic       in_ready2;
  logic       out_valid2;
  logic [3:0] out_onehot2;
  logic [1:0] dec_count2;

  int total = 0;
  int bad   = 0;

  decoder_2x4_stream #(.CODE_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .dec_count(dec_count)
  );

  // Narrow-counter instance shares the stimulus; only its counter is checked.
  decoder_2x4_stream #(.CODE_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready2),
    .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
    .out_onehot(out_onehot2), .dec_count(dec_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b0 || dec_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_hold: valid=%b onehot=%b ready=%b cnt=%0d want 0,0000,0,0",
               out_valid, out_onehot, in_ready, dec_count);
    end
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_decode();
    logic [3:0] exp [4];
    exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_onehot !== exp[i]) begin
        bad++;
        $display("FAIL decode_code%0d: valid=%b onehot=%b want 1,%b", i, out_valid, out_onehot, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || dec_count !== 8'd4) begin
      bad++;
      $display("FAIL decode_count: valid=%b cnt=%0d want 0,4", out_valid, dec_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'd3;
    tick();
    in_code = 2'd1;
    tick();
    in_code = 2'd2;
    total++;
    if (in_ready !== 1'b0 || out_onehot !== 4'b1000) begin
      bad++;
      $display("FAIL bp_full: ready=%b onehot=%b want 0,1000", in_ready, out_onehot);
    end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_onehot !== 4'b1000) begin
      bad++;
      $display("FAIL bp_hold: ready=%b onehot=%b want 0,1000", in_ready, out_onehot);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_onehot !== 4'b0010 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_second: onehot=%b ready=%b want 0010,1", out_onehot, in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_onehot !== 4'b0100 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_third: valid=%b onehot=%b want 1,0100", out_valid, out_onehot);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || dec_count !== 8'd7) begin
      bad++;
      $display("FAIL bp_drain: valid=%b cnt=%0d want 0,7", out_valid, dec_count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'd1;
    tick();
    out_ready = 1'b1;
    in_code = 2'd0;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_onehot !== 4'b0001 || dec_count !== 8'd8) begin
      bad++;
      $display("FAIL b2b_occ1: valid=%b onehot=%b cnt=%0d want 1,0001,8", out_valid, out_onehot, dec_count);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || dec_count !== 8'd9) begin
      bad++;
      $display("FAIL b2b_drain: valid=%b cnt=%0d want 0,9", out_valid, dec_count);
    end
  endtask

  task automatic test_enable();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'd2;
    tick();
    in_code = 2'd3;
    tick();
    en = 1'b0;
    in_code = 2'd0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL en_block: ready=%b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || out_onehot !== 4'b1000) begin
      bad++;
      $display("FAIL en_drain1: ready=%b onehot=%b want 0,1000", in_ready, out_onehot);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || dec_count !== 8'd11) begin
      bad++;
      $display("FAIL en_drain2: valid=%b cnt=%0d want 0,11", out_valid, dec_count);
    end
    in_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 2'd1;
    tick();
    in_code = 2'd2;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || dec_count !== 8'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b onehot=%b cnt=%0d ready=%b want 0,0000,0,0",
               out_valid, out_onehot, dec_count, in_ready);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || dec_count !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_flush: valid=%b cnt=%0d want 0,0", out_valid, dec_count);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp [5];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i % 4);
      tick();
      in_valid = 1'b0;
      tick();
      total++;
      if (dec_count2 !== exp[i] || dec_count !== 8'(i + 1)) begin
        bad++;
        $display("FAIL sat_pop%0d: cnt2=%0d cnt8=%0d want %0d,%0d", i, dec_count2, dec_count, exp[i], i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
